// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding scoreboard.
// Scoreboard entries store the destination register zero-extended to
// WSEL_MAX bits, so REGBITS must not exceed WSEL_MAX.
package hazard_pkg;

    localparam int WSEL_MAX = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [WSEL_MAX-1:0] wsel;
        logic                late;
    } sb_entry_t;

    function automatic int fwd_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: priority matcher for a single source operand. It scans the
// in-flight writers youngest first and reports either a forward stage or a
// stall when the youngest writer's result is not yet available.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NSTAGES    = 3,
    parameter int REGBITS    = 5,
    parameter int LATE_STAGE = 2,
    parameter int SW         = 2
)(
    input  sb_entry_t [NSTAGES:1] entries,
    input  logic                  used,
    input  logic [REGBITS-1:0]    sel,
    output logic [SW-1:0]         fwd_sel,
    output logic                  stall_term
);

    logic found;

    // Youngest matching writer decides; an older ready copy never rescues a younger late one.
    always_comb begin
        fwd_sel    = SW'(FWD_RF);
        stall_term = 1'b0;
        found      = 1'b0;
        for (int j = 1; j <= NSTAGES; j++) begin
            if (!found && used && (sel != '0) && entries[j].valid &&
                (entries[j].wsel == WSEL_MAX'(sel))) begin
                found = 1'b1;
                if (!entries[j].late || (j >= LATE_STAGE)) begin
                    fwd_sel = SW'(j);
                end else begin
                    stall_term = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers across NSTAGES
// post-issue stages and resolves NSRC source operands per cycle into a
// forward select and a load-use stall.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGES    = 3,
    parameter int NSRC       = 2,
    parameter int REGBITS    = 5,
    parameter int LATE_STAGE = 2
)(
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             en,
    input  logic                             flush,
    input  logic                             issue_valid,
    input  logic                             issue_wen,
    input  logic                             issue_late,
    input  logic [REGBITS-1:0]               issue_wsel,
    input  logic [NSRC-1:0]                  src_used,
    input  logic [NSRC*REGBITS-1:0]          src_sel,
    output logic [NSRC*fwd_width(NSTAGES)-1:0] fwd_sel,
    output logic                             stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                      stall_count,
    output logic [31:0]                      fwd_count
`endif
);

    localparam int SW = fwd_width(NSTAGES);

    sb_entry_t [NSTAGES:1] entries;
    sb_entry_t             entry_in;
    logic [NSRC-1:0]       stall_terms;

    // A stalled or flushed issue enters stage 1 as a bubble; r0 writes are never tracked.
    always_comb begin
        entry_in       = '0;
        entry_in.valid = issue_valid & issue_wen & (issue_wsel != '0) & ~stall & ~flush;
        entry_in.wsel  = WSEL_MAX'(issue_wsel);
        entry_in.late  = issue_late;
    end

    // Entries age one stage per advance and hold completely while en is low.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            entries <= '0;
        end else if (en) begin
            for (int j = NSTAGES; j >= 2; j--) begin
                entries[j] <= entries[j-1];
            end
            entries[1] <= entry_in;
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        hazard_match #(
            .NSTAGES    (NSTAGES),
            .REGBITS    (REGBITS),
            .LATE_STAGE (LATE_STAGE),
            .SW         (SW)
        ) u_match (
            .entries    (entries),
            .used       (src_used[k]),
            .sel        (src_sel[k*REGBITS +: REGBITS]),
            .fwd_sel    (fwd_sel[k*SW +: SW]),
            .stall_term (stall_terms[k])
        );
    end

    assign stall = |stall_terms;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        any_fwd;

    assign any_fwd = |fwd_sel;

    // Saturating counters of stall and forwarding cycles seen while the pipe advances.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (en) begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (any_fwd && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: queue-based self-checking bench for hazard_scoreboard.
// Each stimulus cycle pushes its expected {stall, fwd_sel[1], fwd_sel[0]} and
// the value is popped and compared once the combinational outputs settle.
module tb_hazard_scoreboard;

    localparam int NSTAGES    = 3;
    localparam int NSRC       = 2;
    localparam int REGBITS    = 5;
    localparam int LATE_STAGE = 2;
    localparam int SW         = 2;

    logic                      CLK = 1'b0;
    logic                      nRST;
    logic                      en;
    logic                      flush;
    logic                      issue_valid;
    logic                      issue_wen;
    logic                      issue_late;
    logic [REGBITS-1:0]        issue_wsel;
    logic [NSRC-1:0]           src_used;
    logic [NSRC*REGBITS-1:0]   src_sel;
    logic [NSRC*SW-1:0]        fwd_sel;
    logic                      stall;
`ifdef HAZARD_STATS_EN
    logic [31:0]               stall_count;
    logic [31:0]               fwd_count;
    int                        stallCnt = 0;
    int                        fwdCnt   = 0;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [4:0] expQ[$];

    logic       mv[1:3];
    logic [4:0] mw[1:3];
    logic       ml[1:3];

    hazard_scoreboard #(
        .NSTAGES    (NSTAGES),
        .NSRC       (NSRC),
        .REGBITS    (REGBITS),
        .LATE_STAGE (LATE_STAGE)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .en          (en),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_late  (issue_late),
        .issue_wsel  (issue_wsel),
        .src_used    (src_used),
        .src_sel     (src_sel),
        .fwd_sel     (fwd_sel),
        .stall       (stall)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count),
        .fwd_count   (fwd_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [4:0] mk(input int f0, input int f1, input bit st);
        return {st, 2'(f1), 2'(f0)};
    endfunction

    function automatic logic [4:0] predict(input logic [1:0] used, input logic [4:0] s0,
                                           input logic [4:0] s1);
        logic [1:0] f[2];
        logic       st;
        logic [4:0] s;
        bit         hit;
        st = 1'b0;
        for (int k = 0; k < 2; k++) begin
            f[k] = 2'd0;
            hit  = 1'b0;
            s    = (k == 0) ? s0 : s1;
            for (int j = 1; j <= 3; j++) begin
                if (!hit && used[k] && s != 5'd0 && mv[j] && mw[j] == s) begin
                    hit = 1'b1;
                    if (!ml[j] || j >= LATE_STAGE) f[k] = 2'(j);
                    else st = 1'b1;
                end
            end
        end
        return {st, f[1], f[0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rn, input bit e, input bit fl, input bit iv,
                                 input bit iwen, input bit il, input logic [4:0] iw,
                                 input logic [1:0] used, input logic [4:0] s0,
                                 input logic [4:0] s1, input logic [4:0] expv,
                                 input bit useModel, input string tag);
        logic [4:0] mexp;
        logic [4:0] want;
        @(negedge CLK);
        nRST        = rn;
        en          = e;
        flush       = fl;
        issue_valid = iv;
        issue_wen   = iwen;
        issue_late  = il;
        issue_wsel  = iw;
        src_used    = used;
        src_sel     = {s1, s0};
        mexp = predict(used, s0, s1);
        expQ.push_back(useModel ? mexp : expv);
        if (!rn) begin
            for (int j = 1; j <= 3; j++) begin
                mv[j] = 1'b0; mw[j] = 5'd0; ml[j] = 1'b0;
            end
`ifdef HAZARD_STATS_EN
            stallCnt = 0;
            fwdCnt   = 0;
`endif
        end else if (e) begin
`ifdef HAZARD_STATS_EN
            if (mexp[4]) stallCnt++;
            if (mexp[3:0] != 4'd0) fwdCnt++;
`endif
            for (int j = 3; j >= 2; j--) begin
                mv[j] = mv[j-1]; mw[j] = mw[j-1]; ml[j] = ml[j-1];
            end
            mv[1] = iv && iwen && (iw != 5'd0) && !mexp[4] && !fl;
            mw[1] = iw;
            ml[1] = il;
        end
        #1;
        want = expQ.pop_front();
        checkOutput(tag, {27'd0, stall, fwd_sel}, {27'd0, want});
    endtask

    task automatic dir(input bit e, input bit fl, input bit iv, input bit il,
                       input logic [4:0] iw, input logic [1:0] used, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [4:0] expv, input string tag);
        applyStimulus(1'b1, e, fl, iv, iv, il, iw, used, s0, s1, expv, 1'b0, tag);
    endtask

    initial begin
        nRST = 1'b0; en = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_wen = 1'b0;
        issue_late = 1'b0; issue_wsel = '0; src_used = '0; src_sel = '0;
        for (int j = 1; j <= 3; j++) begin
            mv[j] = 1'b0; mw[j] = 5'd0; ml[j] = 1'b0;
        end
        repeat (2) @(posedge CLK);

        dir(1, 0, 0, 0, 0,  2'b11, 3, 8, mk(0, 0, 0), "reset_state");
        dir(1, 0, 1, 0, 3,  2'b00, 0, 0, mk(0, 0, 0), "alu_issue");
        dir(1, 0, 0, 0, 0,  2'b01, 3, 0, mk(1, 0, 0), "alu_stage1");
        dir(1, 0, 0, 0, 0,  2'b01, 3, 0, mk(2, 0, 0), "alu_stage2");
        dir(1, 0, 0, 0, 0,  2'b01, 3, 0, mk(3, 0, 0), "alu_stage3");
        dir(1, 0, 0, 0, 0,  2'b01, 3, 0, mk(0, 0, 0), "alu_dropped");

        dir(1, 0, 1, 1, 8,  2'b00, 0, 0, mk(0, 0, 0), "lw_issue");
        dir(1, 0, 1, 0, 9,  2'b10, 0, 8, mk(0, 0, 1), "lw_use_stall");
        dir(1, 0, 0, 0, 0,  2'b10, 0, 8, mk(0, 2, 0), "lw_use_fwd2");
        dir(1, 0, 0, 0, 0,  2'b10, 0, 9, mk(0, 0, 0), "stalled_issue_bubble");

        dir(1, 0, 1, 0, 5,  2'b00, 0, 0, mk(0, 0, 0), "yw_issue_a");
        dir(1, 0, 1, 0, 7,  2'b00, 0, 0, mk(0, 0, 0), "yw_issue_b");
        dir(1, 0, 1, 0, 5,  2'b01, 5, 0, mk(2, 0, 0), "yw_single");
        dir(1, 0, 0, 0, 0,  2'b01, 5, 0, mk(1, 0, 0), "yw_youngest");
        dir(1, 0, 1, 0, 5,  2'b00, 0, 0, mk(0, 0, 0), "yw_issue_c");
        dir(1, 0, 1, 0, 7,  2'b00, 0, 0, mk(0, 0, 0), "yw_issue_d");
        dir(1, 0, 1, 1, 5,  2'b00, 0, 0, mk(0, 0, 0), "yw_issue_late");
        dir(1, 0, 0, 0, 0,  2'b11, 5, 7, mk(0, 2, 1), "yw_late_wins");
        dir(1, 0, 0, 0, 0,  2'b11, 5, 7, mk(2, 3, 0), "yw_late_ready");

        dir(1, 0, 1, 0, 0,  2'b00, 0, 0, mk(0, 0, 0), "r0_issue");
        dir(1, 0, 0, 0, 0,  2'b11, 0, 0, mk(0, 0, 0), "r0_read");
        dir(1, 0, 1, 0, 6,  2'b00, 0, 0, mk(0, 0, 0), "unused_issue");
        dir(1, 0, 0, 0, 0,  2'b00, 6, 6, mk(0, 0, 0), "unused_src");
        dir(1, 0, 0, 0, 0,  2'b10, 0, 6, mk(0, 2, 0), "used_src1");

        dir(1, 1, 1, 0, 4,  2'b01, 6, 0, mk(3, 0, 0), "flush_issue");
        dir(1, 0, 0, 0, 0,  2'b01, 4, 0, mk(0, 0, 0), "flush_read");

        dir(1, 0, 1, 0, 10, 2'b00, 0, 0, mk(0, 0, 0), "hold_issue");
        for (int i = 0; i < 5; i++) begin
            dir(0, 1, 1, 0, 11, 2'b11, 10, 11, mk(1, 0, 0), "hold_en0");
        end
        dir(1, 0, 0, 0, 0,  2'b11, 10, 11, mk(1, 0, 0), "hold_release");
        dir(1, 0, 0, 0, 0,  2'b01, 10, 0, mk(2, 0, 0), "hold_aged");

        dir(1, 0, 1, 0, 12, 2'b01, 10, 0, mk(3, 0, 0), "rst_fill_a");
        dir(1, 0, 1, 0, 13, 2'b01, 12, 0, mk(1, 0, 0), "rst_fill_b");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b11, 12, 13, mk(2, 1, 0), 1'b0, "rst_cycle");
        dir(1, 0, 0, 0, 0,  2'b11, 12, 13, mk(0, 0, 0), "rst_cleared");

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 60) != 0, $urandom_range(0, 4) != 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0,
                          5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'd0, 1'b1, "rand");
        end

`ifdef HAZARD_STATS_EN
        @(negedge CLK);
        checkOutput("stall_count", stall_count, 32'(stallCnt));
        checkOutput("fwd_count", fwd_count, 32'(fwdCnt));
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5'd0, 1'b1, "stats_reset");
        dir(1, 0, 1, 1, 8, 2'b00, 0, 0, mk(0, 0, 0), "stats_lw_a");
        dir(1, 0, 0, 0, 0, 2'b01, 8, 0, mk(0, 0, 1), "stats_stall_a");
        dir(1, 0, 1, 1, 8, 2'b01, 8, 0, mk(2, 0, 0), "stats_fwd_a");
        dir(1, 0, 0, 0, 0, 2'b10, 0, 8, mk(0, 0, 1), "stats_stall_b");
        dir(1, 0, 1, 1, 8, 2'b10, 0, 8, mk(0, 2, 0), "stats_fwd_b");
        dir(1, 0, 0, 0, 0, 2'b01, 8, 0, mk(0, 0, 1), "stats_stall_c");
        dir(1, 0, 0, 0, 0, 2'b00, 0, 0, mk(0, 0, 0), "stats_idle");
        @(negedge CLK);
        checkOutput("stall_count_3", stall_count, 32'd3);
        checkOutput("fwd_count_2", fwd_count, 32'd2);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        for (int i = 0; i < 4; i++) begin
            dir(1, 0, 1, 1, 8, 2'b00, 0, 0, mk(0, 0, 0), "sat_lw");
            dir(1, 0, 0, 0, 0, 2'b01, 8, 0, mk(0, 0, 1), "sat_stall");
        end
        @(negedge CLK);
        checkOutput("stall_count_sat", stall_count, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
